// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel receive FIFO.
// The CRC constants are used only when PIXEL_FIFO_RX_CRC_EN is defined.
package pixel_pkg;

    localparam int PIXEL_DW = 16;

    typedef logic [PIXEL_DW-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FILL  = 2'd2,
        DRAIN = 2'd3
    } fsm_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // One MSB-first CRC-16-CCITT bit step.
    function automatic logic [15:0] crc16_bit(input logic [15:0] i_crc, input logic i_din);
        logic [15:0] w_shift;
        w_shift = {i_crc[14:0], 1'b0};
        if ((i_crc[15] ^ i_din) == 1'b1) begin
            crc16_bit = w_shift ^ CRC_POLY;
        end else begin
            crc16_bit = w_shift;
        end
    endfunction

endpackage

// File: rtl/pixel_fifo_mem.sv
// DEPTH x DW pixel storage: registered write port, asynchronous read port.
module pixel_fifo_mem
    import pixel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    // Storage write; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pixel_fifo_rx.sv
// Pixel write-protocol receiver: FWFT buffer with x/y tagging and a frame FSM.
// Optional CRC-16-CCITT over each frame when PIXEL_FIFO_RX_CRC_EN is defined.
module pixel_fifo_rx
    import pixel_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 16,
    parameter int HRES  = 640,
    parameter int VRES  = 480,
    parameter int SLACK = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_req,
    output logic          trigger,
    input  logic          fifo_write,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_full,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          rd_en,
    output logic [11:0]   rd_x,
    output logic [11:0]   rd_y,
    output logic          rd_sof,
    output logic          rd_eol,
    output logic          busy,
    output logic          overrun
`ifdef PIXEL_FIFO_RX_CRC_EN
    ,
    output logic [15:0]   crc,
    output logic          crc_valid
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - SLACK);
    localparam logic [11:0]   X_LAST  = 12'(HRES - 1);
    localparam logic [11:0]   Y_LAST  = 12'(VRES - 1);

    fsm_state_t    r_state;
    fsm_state_t    w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    logic [11:0]   r_wx;
    logic [11:0]   r_wy;
    logic [11:0]   r_rx;
    logic [11:0]   r_ry;
    logic          r_full;
    logic          r_overrun;
    logic          w_wr_acc;
    logic          w_pop;
    logic          w_not_empty;
    logic          w_frame_done;
    logic          w_trigger;
    logic          w_busy;
    logic [DW-1:0] w_rd_data;

    assign w_not_empty  = (r_count != {CW{1'b0}});
    assign w_wr_acc     = fifo_write && (r_state == FILL) && (r_count < DEPTH_C);
    assign w_pop        = rd_en && w_not_empty;
    assign w_frame_done = w_wr_acc && (r_wx == X_LAST) && (r_wy == Y_LAST);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (frame_req) begin
                    w_state_nxt = REQ;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            REQ: begin
                w_state_nxt = FILL;
            end
            FILL: begin
                if (w_frame_done) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_state_nxt = FILL;
                end
            end
            DRAIN: begin
                if (!w_not_empty) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = DRAIN;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM output decode; both outputs depend on the state register only.
    always_comb begin
        w_trigger = 1'b0;
        w_busy    = 1'b1;
        case (r_state)
            IDLE:    w_busy    = 1'b0;
            REQ:     w_trigger = 1'b1;
            FILL:    w_busy    = 1'b1;
            DRAIN:   w_busy    = 1'b1;
            default: w_busy    = 1'b0;
        endcase
    end

    // Occupancy after this cycle's accepted write and pop.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_pop})
            2'b10:   w_count_nxt = r_count + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   w_count_nxt = r_count - {{(CW-1){1'b0}}, 1'b1};
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, count, backpressure and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr  <= {AW{1'b0}};
            r_rd_ptr  <= {AW{1'b0}};
            r_count   <= {CW{1'b0}};
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt >= FULL_TH);
            if (fifo_write && !w_wr_acc) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Write-side raster position; restarted for each requested frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wx <= 12'd0;
            r_wy <= 12'd0;
        end else if (r_state == REQ) begin
            r_wx <= 12'd0;
            r_wy <= 12'd0;
        end else if (w_wr_acc) begin
            if (r_wx == X_LAST) begin
                r_wx <= 12'd0;
                r_wy <= (r_wy == Y_LAST) ? 12'd0 : (r_wy + 12'd1);
            end else begin
                r_wx <= r_wx + 12'd1;
            end
        end
    end

    // Read-side raster position of the head pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx <= 12'd0;
            r_ry <= 12'd0;
        end else if (w_pop) begin
            if (r_rx == X_LAST) begin
                r_rx <= 12'd0;
                r_ry <= (r_ry == Y_LAST) ? 12'd0 : (r_ry + 12'd1);
            end else begin
                r_rx <= r_rx + 12'd1;
            end
        end
    end

    pixel_fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (fifo_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign trigger   = w_trigger;
    assign busy      = w_busy;
    assign fifo_full = r_full;
    assign overrun   = r_overrun;
    assign rd_valid  = w_not_empty;
    assign rd_data   = w_rd_data;
    assign rd_x      = r_rx;
    assign rd_y      = r_ry;
    assign rd_sof    = w_not_empty && (r_rx == 12'd0) && (r_ry == 12'd0);
    assign rd_eol    = w_not_empty && (r_rx == X_LAST);

`ifdef PIXEL_FIFO_RX_CRC_EN
    logic [15:0] r_crc;
    logic        r_crc_valid;

    function automatic logic [15:0] crc_pixel(input logic [15:0] i_crc, input logic [DW-1:0] i_pix);
        logic [15:0] w_acc;
        w_acc = i_crc;
        for (int i = DW - 1; i >= 0; i--) begin
            w_acc = crc16_bit(w_acc, i_pix[i]);
        end
        return w_acc;
    endfunction

    // Frame CRC; the valid pulse coincides with the last pixel's update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_crc       <= CRC_INIT;
            r_crc_valid <= 1'b0;
        end else begin
            r_crc_valid <= w_frame_done;
            if (r_state == REQ) begin
                r_crc <= CRC_INIT;
            end else if (w_wr_acc) begin
                r_crc <= crc_pixel(r_crc, fifo_data);
            end
        end
    end

    assign crc       = r_crc;
    assign crc_valid = r_crc_valid;
`endif

endmodule

// File: tb/tb_pixel_fifo_rx.sv
// Self-checking bench for pixel_fifo_rx: queue-based frame model per instance
// plus directed literal checks (CRC instance only with PIXEL_FIFO_RX_CRC_EN).
module tb_pixel_fifo_rx;

`ifdef PIXEL_FIFO_RX_CRC_EN
    localparam int NI = 3;
`else
    localparam int NI = 2;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_a [NI];
    logic        wr_a  [NI];
    logic        rd_a  [NI];
    logic [15:0] dat_a [NI];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL inst%0d %s: got %0h expected %0h at %0t", id, nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_ref(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = r << 1;
            if (fb) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : u
        localparam int H = (g == 2) ? 1 : 4;
        localparam int V = (g == 0) ? 2 : ((g == 1) ? 8 : 1);

        logic        trig, full, rv, sof, eol, bsy, ovr;
        logic [15:0] rdat;
        logic [11:0] rx, ry;
`ifdef PIXEL_FIFO_RX_CRC_EN
        logic [15:0] crc;
        logic        crcv;
`endif

        pixel_fifo_rx #(.DEPTH(16), .DW(16), .HRES(H), .VRES(V), .SLACK(2)) dut (
            .clk        (clk),
            .reset      (reset),
            .frame_req  (req_a[g]),
            .trigger    (trig),
            .fifo_write (wr_a[g]),
            .fifo_data  (dat_a[g]),
            .fifo_full  (full),
            .rd_valid   (rv),
            .rd_data    (rdat),
            .rd_en      (rd_a[g]),
            .rd_x       (rx),
            .rd_y       (ry),
            .rd_sof     (sof),
            .rd_eol     (eol),
            .busy       (bsy),
            .overrun    (ovr)
`ifdef PIXEL_FIFO_RX_CRC_EN
            ,
            .crc        (crc),
            .crc_valid  (crcv)
`endif
        );

        // Model: mode 0 idle, 1 request, 2 filling, 3 draining
        logic [15:0] q[$];
        int          mode, wcnt, popn;
        bit          m_full, m_ovr, m_crcv;
        logic [15:0] m_crc;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                q.delete();
                mode = 0; wcnt = 0; popn = 0;
                m_full = 0; m_ovr = 0; m_crcv = 0; m_crc = 16'hFFFF;
            end else begin
                int n0;
                bit pop, acc;
                n0     = q.size();
                pop    = rd_a[g] && (n0 > 0);
                acc    = wr_a[g] && (mode == 2) && (n0 < 16);
                m_crcv = 0;
                if (wr_a[g] && !acc) m_ovr = 1;
                if (pop) begin
                    void'(q.pop_front());
                    popn = (popn + 1) % (H * V);
                end
                if (acc) begin
                    q.push_back(dat_a[g]);
                    wcnt++;
                    m_crc = crc_ref(m_crc, dat_a[g]);
                end
                case (mode)
                    0: if (req_a[g]) mode = 1;
                    1: begin mode = 2; wcnt = 0; m_crc = 16'hFFFF; end
                    2: if (acc && wcnt == H * V) begin mode = 3; m_crcv = 1; end
                    default: if (n0 == 0) mode = 0;
                endcase
                m_full = (q.size() >= 14);
            end
        end

        always @(negedge clk) begin
            if (!reset) begin
                chk(g, "trigger",   32'(trig), 32'(mode == 1));
                chk(g, "busy",      32'(bsy),  32'(mode != 0));
                chk(g, "rd_valid",  32'(rv),   32'(q.size() > 0));
                chk(g, "fifo_full", 32'(full), 32'(m_full));
                chk(g, "overrun",   32'(ovr),  32'(m_ovr));
                chk(g, "rd_x",      32'(rx),   32'(popn % H));
                chk(g, "rd_y",      32'(ry),   32'(popn / H));
                chk(g, "rd_sof",    32'(sof),  32'((q.size() > 0) && (popn == 0)));
                chk(g, "rd_eol",    32'(eol),  32'((q.size() > 0) && (popn % H == H - 1)));
                if (q.size() > 0) chk(g, "rd_data", 32'(rdat), 32'(q[0]));
`ifdef PIXEL_FIFO_RX_CRC_EN
                chk(g, "crc_valid", 32'(crcv), 32'(m_crcv));
                if (m_crcv) chk(g, "crc", 32'(crc), 32'(m_crc));
`endif
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req_a[i] = 1'b0; wr_a[i] = 1'b0; rd_a[i] = 1'b0; dat_a[i] = 16'h0000;
        end
        repeat (2) tick;
        chk(0, "rst_valid", 32'(u[0].rv),   32'd0);
        chk(0, "rst_busy",  32'(u[0].bsy),  32'd0);
        chk(0, "rst_full",  32'(u[0].full), 32'd0);
        reset = 1'b0;
        tick;

        // Frame of 4x2 pixels streamed straight through.
        req_a[0] = 1'b1;
        tick;
        req_a[0] = 1'b0;
        chk(0, "trig_hi", 32'(u[0].trig), 32'd1);
        chk(0, "busy_hi", 32'(u[0].bsy),  32'd1);
        tick;
        chk(0, "trig_lo", 32'(u[0].trig), 32'd0);
        rd_a[0] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            wr_a[0]  = 1'b1;
            dat_a[0] = 16'(i);
            tick;
            chk(0, "lit_data", 32'(u[0].rdat), 32'(i));
            chk(0, "lit_x",    32'(u[0].rx),   32'((i - 1) % 4));
            chk(0, "lit_y",    32'(u[0].ry),   32'((i - 1) / 4));
            chk(0, "lit_sof",  32'(u[0].sof),  32'(i == 1));
            chk(0, "lit_eol",  32'(u[0].eol),  32'(i == 4 || i == 8));
        end
        wr_a[0] = 1'b0;
        repeat (2) tick;
        rd_a[0] = 1'b0;
        chk(0, "end_busy", 32'(u[0].bsy), 32'd0);
        chk(0, "clean_ovr", 32'(u[0].ovr), 32'd0);

        // Stray write while idle.
        wr_a[0]  = 1'b1;
        dat_a[0] = 16'hBEEF;
        tick;
        wr_a[0] = 1'b0;
        chk(0, "idle_ovr",   32'(u[0].ovr), 32'd1);
        chk(0, "idle_valid", 32'(u[0].rv),  32'd0);

        // Fill to capacity with no reads, then one write too many.
        req_a[1] = 1'b1;
        tick;
        req_a[1] = 1'b0;
        tick;
        for (int i = 1; i <= 17; i++) begin
            wr_a[1]  = 1'b1;
            dat_a[1] = 16'h0100 + 16'(i);
            tick;
            chk(1, "lit_full", 32'(u[1].full), 32'(i >= 14));
            chk(1, "lit_ovr",  32'(u[1].ovr),  32'(i >= 17));
        end
        wr_a[1] = 1'b0;
        rd_a[1] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk(1, "lit_drain", 32'(u[1].rdat), 32'(16'h0101 + 16'(k)));
            tick;
        end
        rd_a[1] = 1'b0;
        chk(1, "empty", 32'(u[1].rv), 32'd0);

        // Reset with five pixels buffered mid-frame.
        for (int i = 1; i <= 5; i++) begin
            wr_a[1]  = 1'b1;
            dat_a[1] = 16'h0200 + 16'(i);
            tick;
        end
        wr_a[1] = 1'b0;
        chk(1, "pre_rst_valid", 32'(u[1].rv), 32'd1);
        reset = 1'b1;
        tick;
        chk(1, "mid_rst_valid", 32'(u[1].rv),   32'd0);
        chk(1, "mid_rst_busy",  32'(u[1].bsy),  32'd0);
        chk(1, "mid_rst_full",  32'(u[1].full), 32'd0);
        chk(1, "mid_rst_ovr",   32'(u[1].ovr),  32'd0);
        reset = 1'b0;
        tick;

`ifdef PIXEL_FIFO_RX_CRC_EN
        // One-pixel frame of zero data.
        req_a[2] = 1'b1;
        tick;
        req_a[2] = 1'b0;
        tick;
        wr_a[2]  = 1'b1;
        dat_a[2] = 16'h0000;
        tick;
        wr_a[2] = 1'b0;
        chk(2, "lit_crcv", 32'(u[2].crcv), 32'd1);
        chk(2, "lit_crc",  32'(u[2].crc),  32'h1D0F);
        rd_a[2] = 1'b1;
        tick;
        chk(2, "lit_crcv_lo", 32'(u[2].crcv), 32'd0);
        rd_a[2] = 1'b0;
        repeat (2) tick;
`endif

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_fifo_rx.md
Name: pixel_fifo_rx

Overview:
- Receiving end of the renderer's pixel write protocol (fifo_write / fifo_data / fifo_full) in the clk domain.
- Stores pixels in a DEPTH-entry buffer and presents them first-word-fall-through to a scanout or line-buffer consumer, tagged with x/y position.
- A small frame FSM issues the trigger pulse that starts the renderer and tracks frame completion.
- Flags protocol violations: overflow writes, and writes outside a frame.

Parameters:
- DEPTH, 16, buffer entries; power of 2, at least 4.
- DW, 16, pixel width (RGB565).
- HRES, 640, pixels per line.
- VRES, 480, lines per frame.
- SLACK, 2, entries kept free after fifo_full asserts, to absorb writer pipeline latency.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high; clears all state.
- frame_req  input  1  consumer requests a new frame.
- trigger  output  1  one-cycle pulse to the writer: start rendering a frame.
- fifo_write  input  1  writer strobe; data is valid this cycle.
- fifo_data  input  DW  pixel from the writer.
- fifo_full  output  1  backpressure to the writer; registered.
- rd_valid  output  1  head entry is available (buffer not empty).
- rd_data  output  DW  head pixel.
- rd_en  input  1  pop the head entry; ignored when rd_valid=0.
- rd_x  output  12  column of the head pixel.
- rd_y  output  12  line of the head pixel.
- rd_sof  output  1  head pixel is (0,0).
- rd_eol  output  1  head pixel has x = HRES-1.
- busy  output  1  FSM is not in IDLE.
- overrun  output  1  sticky; a write was dropped.

Behaviour:
- Reset values: trigger=0, fifo_full=0, rd_valid=0, rd_x=0, rd_y=0, rd_sof=0, rd_eol=0, busy=0, overrun=0. Pointers, count and counters are zeroed; FSM goes to IDLE.
- Reset mid-frame: buffered data is discarded, and the FSM returns to IDLE on the next clock.
- FSM states and transitions:
  - IDLE: on frame_req=1 go to REQ.
  - REQ: drive trigger=1 for exactly one cycle, clear the write x/y counters, go to FILL.
  - FILL: accept pixels. When the accepted pixel has wx=HRES-1 and wy=VRES-1, go to DRAIN.
  - DRAIN: when count==0, go to IDLE.
- busy = (state != IDLE).
- Write acceptance: a write is accepted iff fifo_write=1, state=FILL and count<DEPTH.
  - A write while count==DEPTH is dropped and sets overrun, even if the same cycle pops.
  - A write in IDLE, REQ or DRAIN is dropped and sets overrun.
  - overrun clears only on reset.
- fifo_full register: next value is (count_next >= DEPTH-SLACK).
- Write counters: wx increments on each accepted write and wraps at HRES-1 to 0 while incrementing wy.
- Read side:
  - First-word-fall-through: rd_data is the head entry whenever rd_valid=1.
  - A pop occurs iff rd_en=1 and rd_valid=1; rd_en while empty is a no-op.
  - Read latency: a pixel written in cycle N is visible at the head in cycle N+1 at the earliest.
- Simultaneous accepted write and pop: count is unchanged; both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Read counters: rx/ry advance on each pop. rx wraps at HRES-1 and increments ry; ry wraps at VRES-1 to 0.
- Tag outputs: rd_sof = (rx==0 && ry==0); rd_eol = (rx==HRES-1). Both are qualified by rd_valid.
- frame_req asserted while busy is ignored and not queued.

Optional Feature:
- Macro: PIXEL_FIFO_RX_CRC_EN.
- When defined, adds output ports crc (16 bits) and crc_valid (1 bit).
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first) runs over every accepted pixel of a frame; the init value is reloaded in REQ.
  - crc_valid pulses for one cycle on the FILL->DRAIN transition, with crc holding the final value.
- When undefined, these ports and the CRC logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pixel_pkg: pixel_t (DW-bit RGB565 typedef), the fsm_state_t enum (IDLE, REQ, FILL, DRAIN), and the CRC polynomial/init constants.
- One sub-module: pixel_fifo_mem, the DEPTH x DW storage array with registered write and async read. Pointers, count and flags stay in the parent.

Test Plan:
- Reset, then frame_req pulse -> trigger high for exactly 1 cycle, 1 cycle after frame_req; busy=1.
- HRES=4, VRES=2, DEPTH=16; write 8 pixels 0x0001..0x0008 while rd_en=1 -> pops 0x0001..0x0008 in order with (x,y) = (0,0)..(3,1); rd_sof on the first pop, rd_eol on 0x0004 and 0x0008; FSM returns to IDLE once empty.
- rd_en=0 with continuous writes -> fifo_full rises when count reaches 14. Continued writes fill to 16; the 17th write is dropped, overrun=1, and the buffered data is intact.
- Write pulse in IDLE -> dropped; overrun=1; rd_valid stays 0.
- Assert reset at count=5 mid-FILL -> next cycle rd_valid=0, busy=0, fifo_full=0, overrun=0.
- With PIXEL_FIFO_RX_CRC_EN defined: a one-pixel frame (HRES=VRES=1) of data 0x0000 -> crc_valid pulse with crc=0x1D0F.
